// File: rtl/sprite_anim_sequencer.sv
// Per-player sprite animation sequencer: turns button, movement and hit events into
// frame-timed sprite-state codes, changing state only on frame_tick boundaries.
module sprite_anim_sequencer #(
   parameter int unsigned ATK_START_FRAMES = 5,
   parameter int unsigned ATK_END_FRAMES   = 2,
   parameter int unsigned ATK_PULL_FRAMES  = 16,
   parameter int unsigned DIR_START_FRAMES = 4,
   parameter int unsigned DIR_END_FRAMES   = 3,
   parameter int unsigned DIR_PULL_FRAMES  = 15,
   parameter int unsigned HITSTUN_FRAMES   = 12,
   parameter int unsigned CNT_W            = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       btn_attack,
   input  logic       btn_dirattack,
   input  logic       btn_block,
   input  logic       move_fwd,
   input  logic       move_back,
   input  logic       hit_pulse,
   output logic [3:0] state,
   output logic       attack_active,
   output logic       busy,
   output logic       anim_done,
   output logic       blocked
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_WALK      = 4'd1,
      S_WALKBACK  = 4'd2,
      S_ATK_START = 4'd3,
      S_ATK_END   = 4'd4,
      S_ATK_PULL  = 4'd5,
      S_DIR_START = 4'd6,
      S_DIR_END   = 4'd7,
      S_DIR_PULL  = 4'd8,
      S_BLOCK     = 4'd9,
      S_GOTHIT    = 4'd10
   } state_e;

   localparam logic [CNT_W-1:0] ATK_START_LAST = CNT_W'(ATK_START_FRAMES - 1);
   localparam logic [CNT_W-1:0] ATK_END_LAST   = CNT_W'(ATK_END_FRAMES - 1);
   localparam logic [CNT_W-1:0] ATK_PULL_LAST  = CNT_W'(ATK_PULL_FRAMES - 1);
   localparam logic [CNT_W-1:0] DIR_START_LAST = CNT_W'(DIR_START_FRAMES - 1);
   localparam logic [CNT_W-1:0] DIR_END_LAST   = CNT_W'(DIR_END_FRAMES - 1);
   localparam logic [CNT_W-1:0] DIR_PULL_LAST  = CNT_W'(DIR_PULL_FRAMES - 1);
   localparam logic [CNT_W-1:0] HITSTUN_LAST   = CNT_W'(HITSTUN_FRAMES - 1);

   state_e             state_q, state_nxt;
   logic [CNT_W-1:0]   cnt_q, cnt_nxt;
   logic               btn_attack_q, btn_dirattack_q;
   logic               pend_atk, pend_dir, pend_hit;
   logic               atk_req, dir_req, hit_req;
   logic               done_nxt, blocked_nxt;

   // Raw same-cycle events are OR'ed in so a request coinciding with the tick still counts.
   assign atk_req = pend_atk | (btn_attack & ~btn_attack_q);
   assign dir_req = pend_dir | (btn_dirattack & ~btn_dirattack_q);
   assign hit_req = pend_hit | hit_pulse;

   function automatic state_e free_decide(input logic hit, input logic blk, input logic dir,
                                          input logic atk, input logic fwd, input logic back);
      if (hit && blk)      return S_BLOCK;
      else if (hit)        return S_GOTHIT;
      else if (blk)        return S_BLOCK;
      else if (dir)        return S_DIR_START;
      else if (atk)        return S_ATK_START;
      else if (fwd ^ back) return fwd ? S_WALK : S_WALKBACK;
      else                 return S_IDLE;
   endfunction

   function automatic logic [CNT_W-1:0] last_cnt(input state_e s);
      case (s)
         S_ATK_START: return ATK_START_LAST;
         S_ATK_END:   return ATK_END_LAST;
         S_ATK_PULL:  return ATK_PULL_LAST;
         S_DIR_START: return DIR_START_LAST;
         S_DIR_END:   return DIR_END_LAST;
         S_DIR_PULL:  return DIR_PULL_LAST;
         S_GOTHIT:    return HITSTUN_LAST;
         default:     return '0;
      endcase
   endfunction

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt   = state_q;
      cnt_nxt     = cnt_q;
      done_nxt    = 1'b0;
      blocked_nxt = 1'b0;
      if (frame_tick) begin
         case (state_q)
            S_IDLE, S_WALK, S_WALKBACK, S_BLOCK: begin
               state_nxt   = free_decide(hit_req, btn_block, dir_req, atk_req, move_fwd, move_back);
               cnt_nxt     = '0;
               blocked_nxt = hit_req & btn_block;
            end
            S_ATK_START, S_ATK_END, S_ATK_PULL,
            S_DIR_START, S_DIR_END, S_DIR_PULL, S_GOTHIT: begin
               if (hit_req) begin
                  state_nxt = S_GOTHIT;
                  cnt_nxt   = '0;
               end else if (cnt_q == last_cnt(state_q)) begin
                  cnt_nxt = '0;
                  case (state_q)
                     S_ATK_START: state_nxt = S_ATK_END;
                     S_ATK_END:   state_nxt = S_ATK_PULL;
                     S_DIR_START: state_nxt = S_DIR_END;
                     S_DIR_END:   state_nxt = S_DIR_PULL;
                     default: begin
                        state_nxt = free_decide(1'b0, btn_block, 1'b0, 1'b0, move_fwd, move_back);
                        done_nxt  = 1'b1;
                     end
                  endcase
               end else if (cnt_q != '1) begin
                  cnt_nxt = cnt_q + 1'b1;
               end
            end
            default: begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         cnt_q           <= '0;
         // NOTE: previous-button flops reset high so a button held through reset is not seen as a press.
         btn_attack_q    <= 1'b1;
         btn_dirattack_q <= 1'b1;
         pend_atk        <= 1'b0;
         pend_dir        <= 1'b0;
         pend_hit        <= 1'b0;
         attack_active   <= 1'b0;
         busy            <= 1'b0;
         anim_done       <= 1'b0;
         blocked         <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
         state_q         <= state_nxt;
         cnt_q           <= cnt_nxt;
         btn_attack_q    <= btn_attack;
         btn_dirattack_q <= btn_dirattack;
         pend_atk        <= frame_tick ? 1'b0 : atk_req;
         pend_dir        <= frame_tick ? 1'b0 : dir_req;
         pend_hit        <= frame_tick ? 1'b0 : hit_req;
         attack_active   <= state_nxt inside {S_ATK_END, S_DIR_END};
         busy            <= state_nxt inside {S_ATK_START, S_ATK_END, S_ATK_PULL,
                                              S_DIR_START, S_DIR_END, S_DIR_PULL, S_GOTHIT};
         anim_done       <= done_nxt;
         blocked         <= blocked_nxt;
      end
   end

   assign state = state_q;

endmodule
